voice_sequencer: RTL and testbench

Frame-level controller that shares the per-sample update of up to NUM_VOICES sine_reader instances between codec frames. On each frame request it latches the pending note step sizes and enable mask. It then pulses each enabled reader's generate_next in index order, waits for that reader's sample_ready, and accumulates its sample. Finally it emits one scaled, saturated 16-bit mix sample toward the codec interface.

---
 rtl/voice_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_voice_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sequencer.sv
// Frame sequencer: on each frame request, steps every enabled sine_reader once in index order,
// accumulates their samples, and emits one scaled, saturated 16-bit mix sample.
module voice_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int TIMEOUT    = 15,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_frame,
    input  logic                     load_steps,
    input  logic [20*NUM_VOICES-1:0] voice_step_in,
    input  logic [NUM_VOICES-1:0]    voice_enable_in,
    output logic [20*NUM_VOICES-1:0] step_size,
    output logic [NUM_VOICES-1:0]    generate_next,
    input  logic [NUM_VOICES-1:0]    sample_ready,
    input  logic [16*NUM_VOICES-1:0] sample,
    output logic [15:0]              mix_out,
    output logic                     mix_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int LOG_V = $clog2(NUM_VOICES);
    localparam int AW    = 16 + LOG_V;
    localparam int VW    = (NUM_VOICES > 1) ? LOG_V : 1;
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SKIP, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [VW-1:0]              v_q, v_d;
    logic [CW-1:0]              wait_q, wait_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [20*NUM_VOICES-1:0]   shadow_step_q, shadow_step_d;
    logic [NUM_VOICES-1:0]      shadow_en_q, shadow_en_d;
    logic [20*NUM_VOICES-1:0]   act_step_q, act_step_d;
    logic [NUM_VOICES-1:0]      act_en_q, act_en_d;
    logic [15:0]                mix_q, mix_d;
    logic                       overrun_q, overrun_d;
    logic                       timeout_q, timeout_d;

    logic signed [15:0]         samp_arr [NUM_VOICES];
    logic signed [15:0]         samp_cur;
    logic signed [AW-1:0]       shifted;
    logic [15:0]                sat_val;
    logic                       last_voice;
    logic [VW-1:0]              v_next;
    logic                       next_en;
    logic                       adv;
    logic [NUM_VOICES-1:0]      frame_en;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_unpack
        assign samp_arr[g] = sample[16*g +: 16];
    end

    assign samp_cur   = samp_arr[v_q];
    assign last_voice = (v_q == VW'(NUM_VOICES - 1));
    assign v_next     = v_q + VW'(1);
    assign next_en    = last_voice ? 1'b0 : act_en_q[v_next];

    always_comb begin
        shifted = acc_q >>> GAIN_SHIFT;
        if (shifted > SAT_MAX)
            sat_val = 16'h7FFF;
        else if (shifted < SAT_MIN)
            sat_val = 16'h8000;
        else
            sat_val = shifted[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            v_q           <= '0;
            wait_q        <= '0;
            acc_q         <= '0;
            shadow_step_q <= '0;
            shadow_en_q   <= '0;
            act_step_q    <= '0;
            act_en_q      <= '0;
            mix_q         <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_q           <= v_d;
            wait_q        <= wait_d;
            acc_q         <= acc_d;
            shadow_step_q <= shadow_step_d;
            shadow_en_q   <= shadow_en_d;
            act_step_q    <= act_step_d;
            act_en_q      <= act_en_d;
            mix_q         <= mix_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        v_d           = v_q;
        wait_d        = wait_q;
        acc_d         = acc_q;
        shadow_step_d = shadow_step_q;
        shadow_en_d   = shadow_en_q;
        act_step_d    = act_step_q;
        act_en_d      = act_en_q;
        mix_d         = mix_q;
        overrun_d     = overrun_q;
        timeout_d     = timeout_q;
        adv           = 1'b0;
        frame_en      = load_steps ? voice_enable_in : shadow_en_q;

        if (load_steps) begin
            shadow_step_d = voice_step_in;
            shadow_en_d   = voice_enable_in;
        end
        if (new_frame && (state_q != S_IDLE))
            overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (new_frame) begin
                    // a load in the same cycle as the frame request takes effect immediately
                    act_step_d = load_steps ? voice_step_in : shadow_step_q;
                    act_en_d   = frame_en;
                    acc_d      = '0;
                    v_d        = '0;
                    state_d    = frame_en[0] ? S_ISSUE : S_SKIP;
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sample_ready[v_q]) begin
                    acc_d = acc_q + AW'(samp_cur);
                    adv   = 1'b1;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    adv       = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_SKIP: adv = 1'b1;
            S_DONE: begin
                mix_d   = sat_val;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (last_voice) begin
                state_d = S_DONE;
            end else begin
                v_d     = v_next;
                state_d = next_en ? S_ISSUE : S_SKIP;
            end
        end
    end

    always_comb begin
        generate_next = '0;
        if (state_q == S_ISSUE)
            generate_next[v_q] = 1'b1;
        mix_valid   = (state_q == S_DONE);
        mix_out     = (state_q == S_DONE) ? sat_val : mix_q;
        busy        = (state_q != S_IDLE);
        step_size   = act_step_q;
        overrun     = overrun_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// Bench for voice_sequencer: vector table, hand-written corner sequences and randomized frames
// against a frame-cost reference model.
module tb_voice_sequencer;

    localparam int N  = 4;
    localparam int TO = 15;
    localparam logic [79:0] STEPS = {20'h20000, 20'h18000, 20'h10000, 20'h08000};
    localparam logic [79:0] ALT   = {20'h0ABCD, 20'h0ABCD, 20'h0ABCD, 20'h0ABCD};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_frame = 1'b0;
    logic        load_steps = 1'b0;
    logic [79:0] voice_step_in = '0;
    logic [3:0]  voice_enable_in = '0;
    logic [79:0] step_size, step_size_g0;
    logic [3:0]  generate_next, generate_next_g0;
    logic [3:0]  sample_ready = '0;
    logic [63:0] sample;
    logic [15:0] mix_out, mix_out_g0;
    logic        mix_valid, mix_valid_g0, busy, busy_g0;
    logic        overrun, overrun_g0, timeout_err, timeout_err_g0;

    int checks = 0;
    int errors = 0;

    int                 lat [N];
    logic signed [15:0] smp [N];
    int                 cnt [N];
    bit                 armed [N];

    assign sample = {smp[3], smp[2], smp[1], smp[0]};

    voice_sequencer #(.NUM_VOICES(N), .TIMEOUT(TO), .GAIN_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame), .load_steps(load_steps),
        .voice_step_in(voice_step_in), .voice_enable_in(voice_enable_in),
        .step_size(step_size), .generate_next(generate_next),
        .sample_ready(sample_ready), .sample(sample),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err));

    voice_sequencer #(.NUM_VOICES(N), .TIMEOUT(TO), .GAIN_SHIFT(0)) dut_g0 (
        .clk(clk), .reset(reset), .new_frame(new_frame), .load_steps(load_steps),
        .voice_step_in(voice_step_in), .voice_enable_in(voice_enable_in),
        .step_size(step_size_g0), .generate_next(generate_next_g0),
        .sample_ready(sample_ready), .sample(sample),
        .mix_out(mix_out_g0), .mix_valid(mix_valid_g0), .busy(busy_g0),
        .overrun(overrun_g0), .timeout_err(timeout_err_g0));

    always #5 clk = ~clk;

    // reader model: ready for one cycle in the lat-th cycle after its pulse; lat 0 = never
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            sample_ready[i] = 1'b0;
            if (reset) begin
                armed[i] = 1'b0;
            end else if (generate_next[i]) begin
                armed[i] = (lat[i] > 0);
                cnt[i]   = lat[i] - 1;
            end else if (armed[i]) begin
                if (cnt[i] == 0) begin
                    sample_ready[i] = 1'b1;
                    armed[i]        = 1'b0;
                end else begin
                    cnt[i]--;
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // frame cost: disabled 1 cycle, answered 1+lat, timed out 1+TO; DONE follows the last voice
    task automatic model(input logic [3:0] en, output int done, output int pc [N],
                         output int mix, output int mix0, output bit to);
        int t = 1;
        int acc = 0;
        to = 1'b0;
        for (int i = 0; i < N; i++) begin
            pc[i] = 0;
            if (en[i]) begin
                pc[i] = t;
                if (lat[i] >= 1 && lat[i] <= TO) begin
                    acc += int'(smp[i]);
                    t   += 1 + lat[i];
                end else begin
                    to = 1'b1;
                    t += 1 + TO;
                end
            end else begin
                t += 1;
            end
        end
        done = t;
        mix  = sat16(acc >>> 2);
        mix0 = sat16(acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst step_size", step_size, 0);
        chk("rst generate_next", generate_next, 0);
        chk("rst mix_out", mix_out, 0);
        chk("rst mix_valid", mix_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        chk("rst timeout_err", timeout_err, 0);
    endtask

    task automatic load(input logic [79:0] steps, input logic [3:0] en);
        @(negedge clk);
        load_steps      = 1'b1;
        voice_step_in   = steps;
        voice_enable_in = en;
        @(negedge clk);
        load_steps = 1'b0;
    endtask

    // cycle 0 is the cycle new_frame is presented; exp_done 0 means no mix_valid expected
    task automatic run_frame(input string nm, input logic [3:0] en, input logic [79:0] exp_steps,
                             input int exp_done, input int exp_mix, input int exp_mix0,
                             input bit bypass, input int nf_at, input int load_at, input int rst_at);
        int got_done = 0;
        int multi = 0;
        int pg [N];
        int mp [N];
        int md, m, m0;
        bit mto;
        int bound;
        model(en, md, mp, m, m0, mto);
        for (int i = 0; i < N; i++) pg[i] = 0;
        bound = (exp_done > 0) ? exp_done + 2 : 30;
        @(negedge clk);
        new_frame = 1'b1;
        if (bypass) begin
            load_steps      = 1'b1;
            voice_step_in   = exp_steps;
            voice_enable_in = en;
        end
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            new_frame  = (c == nf_at);
            load_steps = (c == load_at);
            if (c == load_at) voice_step_in = ALT;
            reset = (c == rst_at);
            if (generate_next != 0) begin
                if (!$onehot(generate_next)) multi++;
                for (int i = 0; i < N; i++)
                    if (generate_next[i]) begin
                        if (pg[i] != 0) multi++;
                        pg[i] = c;
                    end
            end
            if (c == 1) begin
                chk({nm, " busy c1"}, busy, 1);
                chk({nm, " step_size"}, step_size, exp_steps);
            end
            if (mix_valid && got_done == 0) begin
                got_done = c;
                chk({nm, " mix_out"}, $signed(mix_out), exp_mix);
                chk({nm, " mix_out g0"}, $signed(mix_out_g0), exp_mix0);
            end
            if (exp_done > 0 && c == exp_done + 1) chk({nm, " busy after done"}, busy, 0);
            if (rst_at != 0 && c == rst_at + 1) begin
                chk({nm, " abort busy"}, busy, 0);
                chk({nm, " abort step_size"}, step_size, 0);
                chk({nm, " abort mix_out"}, mix_out, 0);
                chk({nm, " abort overrun"}, overrun, 0);
            end
        end
        new_frame  = 1'b0;
        load_steps = 1'b0;
        reset      = 1'b0;
        chk({nm, " mix_valid cycle"}, got_done, exp_done);
        chk({nm, " pulse shape"}, multi, 0);
        if (rst_at == 0)
            for (int i = 0; i < N; i++) chk({nm, $sformatf(" pulse v%0d", i)}, pg[i], mp[i]);
    endtask

    typedef struct {
        logic [3:0] en;
        int         l [N];
        int         s [N];
        int         done;
        int         mix;
        int         mix0;
        bit         to;
    } vec_t;

    vec_t tbl [7];

    task automatic set_vec(input int k, input logic [3:0] en,
                           input int l0, input int l1, input int l2, input int l3,
                           input int s0, input int s1, input int s2, input int s3,
                           input int done, input int mix, input int mix0, input bit to);
        tbl[k].en = en;
        tbl[k].l[0] = l0; tbl[k].l[1] = l1; tbl[k].l[2] = l2; tbl[k].l[3] = l3;
        tbl[k].s[0] = s0; tbl[k].s[1] = s1; tbl[k].s[2] = s2; tbl[k].s[3] = s3;
        tbl[k].done = done; tbl[k].mix = mix; tbl[k].mix0 = mix0; tbl[k].to = to;
    endtask

    task automatic set_voices(input int k);
        for (int i = 0; i < N; i++) begin
            lat[i] = tbl[k].l[i];
            smp[i] = 16'(tbl[k].s[i]);
        end
    endtask

    initial begin
        logic [79:0] rsteps;
        logic [3:0]  ren;
        int md, m, m0;
        int mp [N];
        bit mto;
        bit to_sticky;

        for (int i = 0; i < N; i++) begin
            lat[i] = 1; smp[i] = '0; armed[i] = 1'b0; cnt[i] = 0;
        end

        set_vec(0, 4'b0000, 1, 1, 1, 1, 0, 0, 0, 0, 5, 0, 0, 0);
        set_vec(1, 4'b1111, 1, 1, 1, 1, 1000, 2000, -500, 300, 9, 700, 2800, 0);
        set_vec(2, 4'b1111, 1, 1, 1, 1, 32767, 32767, 32767, 32767, 9, 32767, 32767, 0);
        set_vec(3, 4'b1111, 1, 1, 1, 1, -32768, -32768, -32768, -32768, 9, -32768, -32768, 0);
        set_vec(4, 4'b1111, 1, 1, 0, 1, 1000, 2000, -500, 300, 23, 825, 3300, 1);
        set_vec(5, 4'b1010, 2, 3, 1, 1, 100, -200, 300, -400, 9, -150, -600, 0);
        set_vec(6, 4'b1111, 1, 2, 1, 15, -1, 0, 0, 0, 24, -1, -1, 0);

        repeat (3) @(negedge clk);

        // vector table: all-disabled frame runs on reset defaults, the rest load STEPS
        for (int k = 0; k < 7; k++) begin
            do_reset();
            set_voices(k);
            if (k != 0) load(STEPS, tbl[k].en);
            run_frame($sformatf("vec%0d", k), tbl[k].en, (k == 0) ? 80'd0 : STEPS,
                      tbl[k].done, tbl[k].mix, tbl[k].mix0, 1'b0, 0, 0, 0);
            chk($sformatf("vec%0d timeout_err", k), timeout_err, tbl[k].to);
            chk($sformatf("vec%0d overrun", k), overrun, 0);
        end

        // dropped frame request and mid-frame load
        do_reset();
        set_voices(1);
        load(STEPS, 4'b1111);
        run_frame("overrun", 4'b1111, STEPS, 9, 700, 2800, 1'b0, 3, 4, 0);
        chk("overrun flag", overrun, 1);
        run_frame("next frame", 4'b1111, ALT, 9, 700, 2800, 1'b0, 0, 0, 0);
        chk("overrun sticky", overrun, 1);

        // load in the same cycle as the frame request is used immediately
        do_reset();
        load(STEPS, 4'b0000);
        run_frame("bypass", 4'b1111, ALT, 9, 700, 2800, 1'b1, 0, 0, 0);

        // reset in cycle 4 aborts the frame; a fresh frame then runs normally
        do_reset();
        load(STEPS, 4'b1111);
        run_frame("abort", 4'b1111, STEPS, 0, 0, 0, 1'b0, 0, 0, 4);
        load(STEPS, 4'b1111);
        run_frame("after abort", 4'b1111, STEPS, 9, 700, 2800, 1'b0, 0, 0, 0);

        // randomized frames against the model; latencies beyond TO exercise timeout and stray ready
        do_reset();
        to_sticky = 1'b0;
        for (int r = 0; r < 25; r++) begin
            ren = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                lat[i] = $urandom_range(0, 18);
                smp[i] = 16'($urandom);
                rsteps[20*i +: 20] = 20'($urandom);
            end
            load(rsteps, ren);
            model(ren, md, mp, m, m0, mto);
            to_sticky |= mto;
            run_frame($sformatf("rand%0d", r), ren, rsteps, md, m, m0, 1'b0, 0, 0, 0);
            chk($sformatf("rand%0d timeout_err", r), timeout_err, to_sticky);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
